fb_write_sink: RTL and testbench
================================

# fb_write_sink

Memory-side responder for the pixel-writer DRAM request interface: it accepts command/address (af) and write-data (wdf) FIFO writes from a producer such as the line engine, buffers them, and decodes every enabled 32-bit pixel into an (x, y, color) stream. It is used as the DRAM stand-in in simulation and as a frame-write monitor in front of the real memory controller. Its occupancy-driven full flags give producers genuine backpressure.

## Interface
Parameters:
- AF_DEPTH, 4: af FIFO entries (power of two, ≥2).
- WDF_DEPTH, 8: wdf FIFO entries (power of two, ≥2·AF_DEPTH not required).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- af_cmd_din  in  3  request command; 3'b000 = write, anything else is illegal.
- af_addr_din  in  31  [30:19] frame tag, [18:9] y, [8:2] x/8.
- af_wr_en  in  1  push af entry.
- af_full  out  1  af FIFO full.
- wdf_din  in  128  one beat = 4 pixels; pixel k at [127-32k -: 32].
- wdf_mask_din  in  16  byte mask, 1 = byte disabled; nibble [15-4k -: 4] belongs to pixel k.
- wdf_wr_en  in  1  push wdf beat.
- wdf_full  out  1  wdf FIFO full.
- frame_tag  in  12  accepted value of af_addr[30:19].
- px_valid  out  1  decoded pixel available.
- px_ready  in  1  consumer accepts pixel.
- px_x, px_y  out  10 each  pixel coordinates.
- px_color  out  32  pixel data.
- drop_count  out  16  bursts discarded on tag mismatch (wraps).
- err  out  3  sticky: [0] push while full, [1] illegal cmd, [2] partial pixel mask.

## Operation
- Burst = one af write entry + two wdf beats; beat 0 covers x = {addr[8:2],3'd0..3}, beat 1 covers {addr[8:2],3'd4..7}; y = addr[18:9].
- Both FIFOs: push on wr_en & !full; push while full dropped, err[0] set.
- FSM IDLE / SCAN / DRAIN:
  - IDLE: af nonempty & cmd≠000 → pop af, set err[1], stay IDLE (wdf untouched). af nonempty & cmd=000 & wdf count ≥2 → SCAN, slot=0; if tag≠frame_tag → DRAIN.
  - SCAN: slot 0–7, one slot per cycle; beat = slot[2]. Nibble 4'h0 → pixel emitted; 4'hF → skipped; other → skipped, err[2] set. After slot 7 completes: pop af + 2 wdf beats, → IDLE.
  - DRAIN: pop af + 2 wdf beats in one cycle, drop_count+1, → IDLE.
- px_valid registered; px_x/px_y/px_color held stable while px_valid & !px_ready; slot does not advance during stall.
- Pops and pushes on the same cycle legal in all states; count updates by net.
- err cleared only by rst.

## Timing
- Reset: af_full=0, wdf_full=0, px_valid=0, px_x=px_y=0, px_color=0, drop_count=0, err=0, FIFOs empty, FSM IDLE, LFSR seeded.
- af_full/wdf_full registered from next-state occupancy: high the cycle after the push that fills, low the cycle after the freeing pop.
- Latency: af + second wdf beat pushed at edge t → IDLE decides at t+1 → slot 0 px_valid at t+2.
- Unstalled burst: 8 SCAN cycles + 1 IDLE cycle; back-to-back bursts 9 cycles each.
- rst mid-burst: burst abandoned, no further pixels, buffered entries lost.

## Configuration
- FB_SINK_STALL_INJECT_EN defined: 16-bit LFSR (x^16+x^14+x^13+x^11, seed 16'hACE1) steps every cycle; when lfsr[1:0]==2'b00, af_full and wdf_full forced high that cycle and pushes then are dropped with err[0]. Undefined: full flags reflect occupancy only; LFSR absent.

## Test plan
- af addr y=5, x/8=3, tag ok; beat0 mask 16'h0FFF data 0xAABBCCDD in pixel 0; beat1 mask 16'hFFFF -> exactly one pixel x=24 y=5 color 0xAABBCCDD at t+2.
- Full unmasked burst at y=0 x/8=0, px_ready=1 -> px_x 0..7 on 8 consecutive cycles, colors in slot order.
- Same burst, px_ready low 5 cycles on slot 2 -> px_x=2 and color held 5 cycles, then 3..7 follow.
- 4 af pushes, no wdf -> af_full=1 after 4th; 5th push -> err[0]=1, FIFO unchanged.
- tag mismatch burst -> no px_valid, drop_count=1, wdf empty afterwards; then af cmd 3'b001 -> err[1]=1, af empty.
- rst asserted at slot 4 -> px_valid=0 next cycle, flags and counters zero.

Source files
------------

// File: rtl/fb_write_sink.sv
// fb_write_sink: buffers pixel-writer af/wdf requests and decodes enabled pixels into an (x, y, color) stream.
// Optional stall injection on the full flags: `define FB_SINK_STALL_INJECT_EN.

module fb_write_sink_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [1:0]    pop_n,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head0,
    output logic [W-1:0]  head1,
    output logic [CW-1:0] count,
    output logic          full
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr1;
    logic [AW:0]   rd_sum;
    logic [CW-1:0] count_nxt;

    assign count_nxt = count + CW'(push) - CW'(pop_n);
    assign rd_sum    = {1'b0, rd_ptr} + (AW+1)'(pop_n);
    assign rd_ptr1   = rd_ptr + 1'b1;
    assign head0     = mem[rd_ptr];
    assign head1     = mem[rd_ptr1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_sum[AW-1:0];
            count  <= count_nxt;
            // registered from next occupancy so producers see it one cycle after the filling push
            full   <= (count_nxt == CW'(DEPTH));
        end
    end
endmodule

module fb_write_sink #(
    parameter int AF_DEPTH  = 4,
    parameter int WDF_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   af_cmd_din,
    input  logic [30:0]  af_addr_din,
    input  logic         af_wr_en,
    output logic         af_full,
    input  logic [127:0] wdf_din,
    input  logic [15:0]  wdf_mask_din,
    input  logic         wdf_wr_en,
    output logic         wdf_full,
    input  logic [11:0]  frame_tag,
    output logic         px_valid,
    input  logic         px_ready,
    output logic [9:0]   px_x,
    output logic [9:0]   px_y,
    output logic [31:0]  px_color,
    output logic [15:0]  drop_count,
    output logic [2:0]   err
);
    localparam int AF_CW  = $clog2(AF_DEPTH) + 1;
    localparam int WDF_CW = $clog2(WDF_DEPTH) + 1;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [30:0] addr;
    } af_entry_t;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  mask;
    } wdf_entry_t;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    logic stall;
`ifdef FB_SINK_STALL_INJECT_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    logic af_full_q, wdf_full_q;
    logic af_push, wdf_push;
    logic af_pop, wdf_pop2;
    af_entry_t  af_din, af_head, af_head1;
    wdf_entry_t wdf_in, wdf_b0, wdf_b1;
    logic [AF_CW-1:0]  af_count;
    logic [WDF_CW-1:0] wdf_count;

    assign af_full  = af_full_q | stall;
    assign wdf_full = wdf_full_q | stall;
    assign af_push  = af_wr_en & ~af_full;
    assign wdf_push = wdf_wr_en & ~wdf_full;
    assign af_din   = '{cmd: af_cmd_din, addr: af_addr_din};
    assign wdf_in   = '{data: wdf_din, mask: wdf_mask_din};

    fb_write_sink_fifo #(.W($bits(af_entry_t)), .DEPTH(AF_DEPTH)) u_af_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (af_push),
        .pop_n ({1'b0, af_pop}),
        .din   (af_din),
        .head0 (af_head),
        .head1 (af_head1),
        .count (af_count),
        .full  (af_full_q)
    );

    fb_write_sink_fifo #(.W($bits(wdf_entry_t)), .DEPTH(WDF_DEPTH)) u_wdf_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wdf_push),
        .pop_n ({wdf_pop2, 1'b0}),
        .din   (wdf_in),
        .head0 (wdf_b0),
        .head1 (wdf_b1),
        .count (wdf_count),
        .full  (wdf_full_q)
    );

    logic unused_sink;
    assign unused_sink = &{1'b0, af_head.addr[1:0], af_head1};

    // Slot s covers beat s[2], pixel s[1:0] within that beat
    logic [7:0][31:0] slot_color;
    logic [7:0][3:0]  slot_nib;
    for (genvar s = 0; s < 8; s++) begin : g_slot
        localparam int K = s % 4;
        if (s < 4) begin : g_b0
            assign slot_color[s] = wdf_b0.data[127-32*K -: 32];
            assign slot_nib[s]   = wdf_b0.mask[15-4*K -: 4];
        end else begin : g_b1
            assign slot_color[s] = wdf_b1.data[127-32*K -: 32];
            assign slot_nib[s]   = wdf_b1.mask[15-4*K -: 4];
        end
    end

    state_t     state, state_nxt;
    logic [2:0] slot;
    logic       out_free, scan_step, drop_inc, illegal;
    logic [3:0] cur_nib;

    assign out_free = ~px_valid | px_ready;
    assign cur_nib  = slot_nib[slot];

    always_comb begin
        state_nxt = state;
        af_pop    = 1'b0;
        wdf_pop2  = 1'b0;
        drop_inc  = 1'b0;
        illegal   = 1'b0;
        scan_step = 1'b0;
        case (state)
            IDLE: begin
                if (af_count != '0) begin
                    if (af_head.cmd != 3'b000) begin
                        af_pop  = 1'b1;
                        illegal = 1'b1;
                    end else if (wdf_count >= WDF_CW'(2)) begin
                        state_nxt = (af_head.addr[30:19] == frame_tag) ? SCAN : DRAIN;
                    end
                end
            end
            SCAN: begin
                // a stalled output register freezes the slot walk
                if (out_free) begin
                    scan_step = 1'b1;
                    if (slot == 3'd7) begin
                        af_pop    = 1'b1;
                        wdf_pop2  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                af_pop    = 1'b1;
                wdf_pop2  = 1'b1;
                drop_inc  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            slot       <= 3'd0;
            px_valid   <= 1'b0;
            px_x       <= '0;
            px_y       <= '0;
            px_color   <= '0;
            drop_count <= '0;
            err        <= '0;
        end else begin
            state <= state_nxt;
            if (scan_step) begin
                slot     <= slot + 3'd1;
                px_valid <= (cur_nib == 4'h0);
                if (cur_nib == 4'h0) begin
                    px_x     <= {af_head.addr[8:2], slot};
                    px_y     <= af_head.addr[18:9];
                    px_color <= slot_color[slot];
                end
                if (cur_nib != 4'h0 && cur_nib != 4'hF) err[2] <= 1'b1;
            end else if (px_ready) begin
                px_valid <= 1'b0;
            end
            if (drop_inc) drop_count <= drop_count + 16'd1;
            if (illegal)  err[1] <= 1'b1;
            if ((af_wr_en & af_full) | (wdf_wr_en & wdf_full)) err[0] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fb_write_sink.sv
// Bench for fb_write_sink: directed corner sequences, a vector table, and a randomized run against a burst-level model.
module tb_fb_write_sink;
    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   af_cmd_din;
    logic [30:0]  af_addr_din;
    logic         af_wr_en;
    logic         af_full;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;
    logic         wdf_wr_en;
    logic         wdf_full;
    logic [11:0]  frame_tag;
    logic         px_valid;
    logic         px_ready;
    logic [9:0]   px_x, px_y;
    logic [31:0]  px_color;
    logic [15:0]  drop_count;
    logic [2:0]   err;

    localparam logic [11:0] TAG = 12'h5A3;

    always #5 clk = ~clk;

    fb_write_sink #(.AF_DEPTH(4), .WDF_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din), .af_wr_en(af_wr_en), .af_full(af_full),
        .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en), .wdf_full(wdf_full),
        .frame_tag(frame_tag),
        .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y), .px_color(px_color),
        .drop_count(drop_count), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_ready = 0;
    bit mon_en = 0;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [31:0] c;
    } px_t;
    px_t exp_q [$];

    typedef struct {
        logic [9:0]  y;
        logic [6:0]  x8;
        logic [15:0] m0, m1;
        int          n;
        logic [9:0]  fx, lx;
        logic [2:0]  e;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired, flag still high", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) px_ready = ($urandom_range(0, 3) != 0);
    endtask

    function automatic logic [30:0] mk_addr(input logic [11:0] tg, input logic [9:0] y, input logic [6:0] x8);
        return {tg, y, x8, 2'b00};
    endfunction

    function automatic logic [127:0] mk_data(input logic [7:0] tagb, input int beat);
        logic [127:0] d;
        for (int k = 0; k < 4; k++) d[127-32*k -: 32] = {16'hC0DE, tagb, 8'(beat*4 + k)};
        return d;
    endfunction

    task automatic push_af(input logic [2:0] cmd, input logic [30:0] addr);
        for (int k = 0; k < 400 && af_full; k++) tick();
        if (af_full) timeout("af_full_wait");
        af_cmd_din = cmd; af_addr_din = addr; af_wr_en = 1'b1;
        tick();
        af_wr_en = 1'b0;
    endtask

    task automatic push_beat(input logic [127:0] d, input logic [15:0] m);
        for (int k = 0; k < 400 && wdf_full; k++) tick();
        if (wdf_full) timeout("wdf_full_wait");
        wdf_din = d; wdf_mask_din = m; wdf_wr_en = 1'b1;
        tick();
        wdf_wr_en = 1'b0;
    endtask

    task automatic push_burst(input logic [30:0] addr, input logic [127:0] d0, input logic [15:0] m0,
                              input logic [127:0] d1, input logic [15:0] m1);
        push_af(3'b000, addr);
        push_beat(d0, m0);
        push_beat(d1, m1);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        af_wr_en = 1'b0; wdf_wr_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && px_valid && px_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rnd_extra_px: got x=%0d y=%0d, required no pixel", px_x, px_y);
            end else begin
                px_t e;
                e = exp_q.pop_front();
                chk("rnd_px", 64'({px_x, px_y, px_color}), 64'(e));
            end
        end
    end

    initial begin
        int n;
        int vcnt;
        logic [9:0]  fx, lx, ly;
        logic [31:0] lc;
        logic [127:0] d0, d1;
        logic [15:0]  m0, m1;
        int exp_drop;
        logic [2:0] exp_err;

        vt[0] = '{10'd5,    7'd3,   16'h0FFF, 16'hFFFF, 1, 10'd24,   10'd24,   3'b000};
        vt[1] = '{10'd0,    7'd0,   16'h0000, 16'h0000, 8, 10'd0,    10'd7,    3'b000};
        vt[2] = '{10'd1023, 7'd127, 16'hFFFF, 16'hFFF0, 1, 10'd1023, 10'd1023, 3'b000};
        vt[3] = '{10'd7,    7'd2,   16'hF0F0, 16'h0F0F, 4, 10'd17,   10'd22,   3'b000};
        vt[4] = '{10'd9,    7'd1,   16'hFFFF, 16'hFFFF, 0, 10'd0,    10'd0,    3'b000};
        vt[5] = '{10'd3,    7'd4,   16'h3FFF, 16'hFFFF, 0, 10'd0,    10'd0,    3'b100};

        af_cmd_din = '0; af_addr_din = '0; af_wr_en = 1'b0;
        wdf_din = '0; wdf_mask_din = '0; wdf_wr_en = 1'b0;
        frame_tag = TAG; px_ready = 1'b1;

        reset_dut();
        chk("rst_px_valid", px_valid, 0);
        chk("rst_px_x", px_x, 0);
        chk("rst_px_y", px_y, 0);
        chk("rst_px_color", px_color, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_err", err, 0);
        chk("rst_af_full", af_full, 0);
        chk("rst_wdf_full", wdf_full, 0);

        // single enabled pixel and its latency
        push_burst(mk_addr(TAG, 10'd5, 7'd3), {32'hAABBCCDD, 96'h0}, 16'h0FFF, 128'h0, 16'hFFFF);
        tick();
        chk("lat_t1_valid", px_valid, 0);
        tick();
        chk("lat_t2_valid", px_valid, 1);
        chk("lat_t2_x", px_x, 24);
        chk("lat_t2_y", px_y, 5);
        chk("lat_t2_color", px_color, 32'hAABBCCDD);
        vcnt = 0;
        for (int j = 0; j < 9; j++) begin tick(); if (px_valid) vcnt++; end
        chk("single_extra_px", vcnt, 0);

        // unmasked burst streams one pixel per cycle
        push_burst(mk_addr(TAG, 10'd0, 7'd0), mk_data(8'hEE, 0), 16'h0, mk_data(8'hEE, 1), 16'h0);
        tick();
        for (int s = 0; s < 8; s++) begin
            tick();
            chk("burst_valid", px_valid, 1);
            chk("burst_x", px_x, s);
            chk("burst_color", px_color, {16'hC0DE, 8'hEE, 8'(s)});
        end
        tick();
        chk("burst_end_valid", px_valid, 0);

        // consumer stall on slot 2
        push_burst(mk_addr(TAG, 10'd0, 7'd0), mk_data(8'hEE, 0), 16'h0, mk_data(8'hEE, 1), 16'h0);
        tick(); tick(); tick(); tick();
        chk("stall_pre_x", px_x, 2);
        px_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("stall_valid", px_valid, 1);
            chk("stall_x", px_x, 2);
            chk("stall_color", px_color, {16'hC0DE, 8'hEE, 8'd2});
        end
        px_ready = 1'b1;
        for (int s = 3; s < 8; s++) begin
            tick();
            chk("stall_post_valid", px_valid, 1);
            chk("stall_post_x", px_x, s);
        end
        tick();

        // vector table
        for (int i = 0; i < 6; i++) begin
            push_burst(mk_addr(TAG, vt[i].y, vt[i].x8), mk_data(8'(i), 0), vt[i].m0, mk_data(8'(i), 1), vt[i].m1);
            n = 0; fx = '0; lx = '0; ly = '0; lc = '0;
            for (int j = 0; j < 14; j++) begin
                tick();
                if (px_valid) begin
                    if (n == 0) fx = px_x;
                    n++;
                    lx = px_x; ly = px_y; lc = px_color;
                end
            end
            chk("vec_npx", 64'(n), 64'(vt[i].n));
            chk("vec_first_x", fx, vt[i].fx);
            chk("vec_last_x", lx, vt[i].lx);
            if (n > 0) begin
                chk("vec_y", ly, vt[i].y);
                chk("vec_color", lc, {16'hC0DE, 8'(i), 5'd0, lx[2:0]});
            end
            chk("vec_err", err, vt[i].e);
        end

        // af fills after four entries; a fifth push is refused
        reset_dut();
        af_cmd_din = 3'b000; af_addr_din = mk_addr(TAG, 10'd1, 7'd1); af_wr_en = 1'b1;
        tick(); tick(); tick();
        chk("af_full_3", af_full, 0);
        tick();
        chk("af_full_4", af_full, 1);
        chk("af_err0_pre", err[0], 0);
        tick();
        af_wr_en = 1'b0;
        chk("af_err0", err[0], 1);
        chk("af_full_after", af_full, 1);

        // tag mismatch drained, then illegal command
        reset_dut();
        push_burst(mk_addr(TAG ^ 12'h001, 10'd2, 7'd2), mk_data(8'h11, 0), 16'h0, mk_data(8'h11, 1), 16'h0);
        vcnt = 0;
        for (int j = 0; j < 6; j++) begin tick(); if (px_valid) vcnt++; end
        chk("tag_no_px", vcnt, 0);
        chk("tag_drop", drop_count, 1);
        wdf_din = '0; wdf_mask_din = 16'hFFFF; wdf_wr_en = 1'b1;
        for (int j = 0; j < 7; j++) tick();
        chk("tag_wdf_full_7", wdf_full, 0);
        tick();
        wdf_wr_en = 1'b0;
        chk("tag_wdf_full_8", wdf_full, 1);
        push_af(3'b001, mk_addr(TAG, 10'd0, 7'd0));
        vcnt = 0;
        for (int j = 0; j < 4; j++) begin tick(); if (px_valid) vcnt++; end
        chk("ill_err", err, 3'b010);
        chk("ill_no_px", vcnt, 0);
        chk("ill_wdf_untouched", wdf_full, 1);

        // reset mid-burst
        reset_dut();
        push_burst(mk_addr(TAG, 10'd4, 7'd0), mk_data(8'h22, 0), 16'h0, mk_data(8'h22, 1), 16'h0);
        for (int j = 0; j < 6; j++) tick();
        chk("mid_pre_x", px_x, 4);
        rst = 1'b1;
        tick();
        chk("mid_valid", px_valid, 0);
        chk("mid_x", px_x, 0);
        chk("mid_color", px_color, 0);
        chk("mid_drop", drop_count, 0);
        chk("mid_err", err, 0);
        rst = 1'b0;
        vcnt = 0;
        for (int j = 0; j < 12; j++) begin tick(); if (px_valid) vcnt++; end
        chk("mid_no_px", vcnt, 0);
        chk("mid_af_full", af_full, 0);

        // randomized bursts against a burst-level model
        reset_dut();
        exp_drop = 0;
        exp_err = 3'b000;
        rand_ready = 1;
        mon_en = 1;
        for (int b = 0; b < 40; b++) begin
            int r;
            logic [2:0]  cmd;
            logic [11:0] tg;
            logic [9:0]  y;
            logic [6:0]  x8;
            logic [3:0]  nib [8];
            logic [31:0] col [8];
            r = $urandom_range(0, 19);
            cmd = (r < 2) ? 3'($urandom_range(1, 7)) : 3'b000;
            tg = (r >= 2 && r < 5) ? (TAG ^ 12'($urandom_range(1, 4095))) : TAG;
            y = 10'($urandom);
            x8 = 7'($urandom);
            for (int s = 0; s < 8; s++) begin
                int q;
                q = $urandom_range(0, 19);
                nib[s] = (q < 12) ? 4'h0 : (q < 19) ? 4'hF : 4'h3;
                col[s] = $urandom;
            end
            for (int k = 0; k < 4; k++) begin
                d0[127-32*k -: 32] = col[k];     m0[15-4*k -: 4] = nib[k];
                d1[127-32*k -: 32] = col[k + 4]; m1[15-4*k -: 4] = nib[k + 4];
            end
            if (cmd != 3'b000) begin
                exp_err[1] = 1'b1;
                push_af(cmd, mk_addr(tg, y, x8));
            end else begin
                if (tg != TAG) exp_drop++;
                else begin
                    for (int s = 0; s < 8; s++) begin
                        if (nib[s] == 4'h0) exp_q.push_back('{x: {x8, 3'(s)}, y: y, c: col[s]});
                        else if (nib[s] != 4'hF) exp_err[2] = 1'b1;
                    end
                end
                push_burst(mk_addr(tg, y, x8), d0, m0, d1, m1);
            end
        end
        for (int k = 0; k < 3000 && exp_q.size() > 0; k++) tick();
        if (exp_q.size() > 0) timeout("rnd_drain_wait");
        for (int k = 0; k < 20; k++) tick();
        mon_en = 0;
        rand_ready = 0;
        chk("rnd_left", 64'(exp_q.size()), 0);
        chk("rnd_drop", drop_count, 16'(exp_drop));
        chk("rnd_err", err, exp_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
